// File: rtl/nes_frame_capture_ctrl.sv
// Frame capture sequencer: arms on request, aligns to the pre-render line, then streams
// the visible PPU dots as AXI-Stream beats through a small elastic FIFO.
module nes_frame_capture_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int VIS_W      = 256,
    parameter int VIS_H      = 240,
    parameter int PRE_LINE   = 261
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic [5:0] color,
    input  logic [8:0] scanline,
    input  logic [8:0] cycle,
    input  logic       cap_req,
    input  logic [7:0] cap_frames,
    input  logic       cap_abort,
    output logic       cap_busy,
    output logic       cap_done,
    output logic       ovf,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       m_tlast,
    output logic       m_tuser
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [8:0] VIS_W9    = 9'(VIS_W);
    localparam logic [8:0] VIS_H9    = 9'(VIS_H);
    localparam logic [8:0] LAST_LINE = 9'(VIS_H - 1);
    localparam logic [8:0] PRE_LINE9 = 9'(PRE_LINE);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DRAIN} state_t;

    typedef struct packed {
        logic       user;
        logic       last;
        logic [5:0] color;
    } pix_t;

    state_t      state;
    logic [7:0]  frames_left;

    // one-deep stage between the PPU sample and the FIFO write
    logic        p_vld;
    pix_t        p_pix;

    pix_t        mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr, wptr_nxt, rptr_nxt;
    logic        full, fifo_empty, do_push, do_pop, drop;
    logic        visible, frame_end, abort_act;
    pix_t        head;

    assign visible   = pix_en && (scanline < VIS_H9) && (cycle != 9'd0) && (cycle <= VIS_W9);
    assign frame_end = visible && (scanline == LAST_LINE) && (cycle == VIS_W9);
    assign abort_act = cap_abort && (state != IDLE);

    always_comb begin
        do_pop     = m_tvalid && m_tready;
        full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        fifo_empty = (wptr == rptr);
        // a pop in the same clk frees the slot, so a full FIFO still accepts
        do_push    = p_vld && (!full || do_pop);
        drop       = p_vld && full && !do_pop;
        wptr_nxt   = do_push ? wptr + PTR_ONE : wptr;
        rptr_nxt   = do_pop  ? rptr + PTR_ONE : rptr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frames_left <= 8'd0;
            cap_busy    <= 1'b0;
            cap_done    <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            cap_done <= 1'b0;
            if (drop && !abort_act)
                ovf <= 1'b1;
            if (abort_act) begin
                state    <= IDLE;
                cap_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (cap_req) begin
                        state       <= ARM;
                        cap_busy    <= 1'b1;
                        frames_left <= (cap_frames == 8'd0) ? 8'd1 : cap_frames;
                        ovf         <= 1'b0;
                    end
                    ARM: if (pix_en && scanline == PRE_LINE9)
                        state <= CAPTURE;
                    CAPTURE: if (frame_end) begin
                        frames_left <= frames_left - 8'd1;
                        if (frames_left == 8'd1)
                            state <= DRAIN;
                    end
                    DRAIN: if (!p_vld && fifo_empty) begin
                        state    <= IDLE;
                        cap_busy <= 1'b0;
                        cap_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld    <= 1'b0;
            p_pix    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            m_tvalid <= 1'b0;
        end else if (abort_act) begin
            p_vld    <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            m_tvalid <= 1'b0;
        end else begin
            p_vld <= (state == CAPTURE) && visible;
            if (visible) begin
                p_pix.user  <= (scanline == 9'd0) && (cycle == 9'd1);
                p_pix.last  <= (cycle == VIS_W9);
                p_pix.color <= color;
            end
            wptr     <= wptr_nxt;
            rptr     <= rptr_nxt;
            m_tvalid <= (wptr_nxt != rptr_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= p_pix;
    end

    // head only moves on a pop, so the beat holds steady while stalled
    assign head    = mem[rptr[AW-1:0]];
    assign m_tdata = m_tvalid ? {2'b00, head.color} : 8'h00;
    assign m_tlast = m_tvalid && head.last;
    assign m_tuser = m_tvalid && head.user;

endmodule

// File: tb/tb_nes_frame_capture_ctrl.sv
// Bench for nes_frame_capture_ctrl on a shrunken PPU raster; a dot-level model predicts
// every beat, and a table of capture scenarios plus hand sequences cover the corners.
module tb_nes_frame_capture_ctrl;
    localparam int FD = 16, VW = 8, VH = 4, PL = 6, LINE_LEN = 12;
    localparam int FRAME_DOTS = LINE_LEN * (PL + 1);

    logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
    logic [5:0] color = '0;
    logic [8:0] scanline = '0, cycle = '0;
    logic       cap_req = 1'b0, cap_abort = 1'b0, m_tready = 1'b0;
    logic [7:0] cap_frames = '0;
    logic       cap_busy, cap_done, ovf, m_tvalid, m_tlast, m_tuser;
    logic [7:0] m_tdata;

    nes_frame_capture_ctrl #(.FIFO_DEPTH(FD), .VIS_W(VW), .VIS_H(VH), .PRE_LINE(PL)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .color(color), .scanline(scanline),
        .cycle(cycle), .cap_req(cap_req), .cap_frames(cap_frames), .cap_abort(cap_abort),
        .cap_busy(cap_busy), .cap_done(cap_done), .ovf(ovf), .m_tdata(m_tdata),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // reference model: raster position, capture intent, expected beats
    int         g_sl = 0, g_cy = 0;
    bit         m_armed = 0, m_cap = 0, m_stalled = 0, m_ovf = 0;
    int         m_left = 0, m_held = 0, m_vis = 0;
    logic [7:0] exp_q[$];
    int         pct = 100;

    initial forever begin
        @(posedge clk); #1;
        m_tready = (int'($urandom_range(99)) < pct);
    end

    // monitor: scoreboard, sideband counts, AXIS stability
    int         beats = 0, n_user = 0, n_last = 0, n_done = 0;
    bit         sb_en = 1, prev_hold = 0;
    logic [9:0] prev_beat = '0;
    always @(negedge clk) begin
        if (rst_n && sb_en) begin
            logic [7:0] e;
            if (prev_hold) begin
                chk("hold_valid", int'(m_tvalid), 1);
                chk("hold_data", int'({m_tuser, m_tlast, m_tdata}), int'(prev_beat));
            end
            if (cap_done) begin
                n_done++;
                chk("done_after_last", exp_q.size(), 0);
            end
            if (m_tvalid && m_tready) begin
                beats++; n_user += int'(m_tuser); n_last += int'(m_tlast);
                if (exp_q.size() == 0) chk("beat_unexpected", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("beat", int'({m_tuser, m_tlast, m_tdata}), int'({e[7], e[6], 2'b00, e[5:0]}));
                end
            end
            prev_hold = m_tvalid && !m_tready;
            prev_beat = {m_tuser, m_tlast, m_tdata};
        end else begin
            prev_hold = 0;
            if (rst_n && m_tvalid && m_tready) beats++;
            if (rst_n && cap_done) n_done++;
        end
    end

    task automatic ppu_dot();
        logic [5:0] c;
        bit vis;
        c = 6'($urandom);
        @(posedge clk); #1;
        pix_en = 1'b1; color = c; scanline = 9'(g_sl); cycle = 9'(g_cy);
        vis = (g_sl < VH) && (g_cy >= 1) && (g_cy <= VW);
        if (m_armed && g_sl == PL) begin
            m_armed = 0; m_cap = 1;
        end else if (m_cap && vis) begin
            m_vis++;
            if (!m_stalled || m_held < FD) begin
                exp_q.push_back({1'(g_sl == 0 && g_cy == 1), 1'(g_cy == VW), c});
                if (m_stalled) m_held++;
            end else m_ovf = 1;
            if (g_sl == VH - 1 && g_cy == VW) begin
                m_left--;
                if (m_left == 0) m_cap = 0;
            end
        end
        @(posedge clk); #1;
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        g_cy++;
        if (g_cy == LINE_LEN) begin
            g_cy = 0;
            g_sl = (g_sl == PL) ? 0 : g_sl + 1;
        end
    endtask

    task automatic goto_dot(input int sl, input int cy);
        while (!(g_sl == sl && g_cy == cy)) ppu_dot();
    endtask

    task automatic request(input int frames);
        beats = 0; n_user = 0; n_last = 0; n_done = 0;
        @(posedge clk); #1;
        cap_req = 1'b1; cap_frames = 8'(frames);
        @(posedge clk); #1;
        cap_req = 1'b0; cap_frames = 8'($urandom);
        m_armed = 1; m_left = (frames == 0) ? 1 : frames; m_ovf = 0; m_held = 0; m_vis = 0;
    endtask

    task automatic run_to_done(input int frames);
        int bound;
        bound = ((frames == 0 ? 1 : frames) + 2) * FRAME_DOTS;
        for (int i = 0; i < bound && n_done == 0; i++) ppu_dot();
        repeat (8) @(posedge clk);
    endtask

    task automatic wait_capture_at(input int sl, input int cy);
        int guard = 0;
        while (!(m_cap && g_sl == sl && g_cy == cy) && guard < 3 * FRAME_DOTS) begin
            ppu_dot(); guard++;
        end
        chk("reach_capture_point", int'(guard < 3 * FRAME_DOTS), 1);
    endtask

    typedef struct {
        int frames; int pct; int req_line;
        int exp_beats; int exp_user; int exp_last; int exp_ovf;
    } vec_t;
    vec_t vt[5];

    initial begin
        vt[0] = '{1, 100, 0,  VW*VH,   1, VH,   0};
        vt[1] = '{0, 100, 3,  VW*VH,   1, VH,   0};  // zero frames, request mid-frame
        vt[2] = '{3, 50,  1,  3*VW*VH, 3, 3*VH, 0};
        vt[3] = '{2, 40,  5,  2*VW*VH, 2, 2*VH, 0};
        vt[4] = '{1, 70,  PL, VW*VH,   1, VH,   0};  // request on the pre-render line itself

        repeat (3) @(posedge clk); #1;
        chk("rst_busy", int'(cap_busy), 0);
        chk("rst_done", int'(cap_done), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_tvalid", int'(m_tvalid), 0);
        chk("rst_tlast", int'(m_tlast), 0);
        chk("rst_tuser", int'(m_tuser), 0);
        chk("rst_tdata", int'(m_tdata), 0);
        #2 rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            pct = vt[v].pct;
            goto_dot(vt[v].req_line, 5);
            request(vt[v].frames);
            run_to_done(vt[v].frames);
            chk($sformatf("v%0d_beats", v), beats, vt[v].exp_beats);
            chk($sformatf("v%0d_tuser", v), n_user, vt[v].exp_user);
            chk($sformatf("v%0d_tlast", v), n_last, vt[v].exp_last);
            chk($sformatf("v%0d_done", v), n_done, 1);
            chk($sformatf("v%0d_ovf", v), int'(ovf), vt[v].exp_ovf);
            chk($sformatf("v%0d_busy", v), int'(cap_busy), 0);
            chk($sformatf("v%0d_left", v), exp_q.size(), 0);
        end

        // sink stalled across 20 visible dots: 16 held, later ones dropped
        pct = 0;
        goto_dot(PL, 2);
        m_stalled = 1;
        request(1);
        while (m_vis < 16) ppu_dot();
        chk("ovf_at_16", int'(ovf), 0);
        while (m_vis < 17) ppu_dot();
        chk("ovf_at_17", int'(ovf), 1);
        while (m_vis < 20) ppu_dot();
        chk("stall_beats", beats, 0);
        chk("stall_tvalid", int'(m_tvalid), 1);
        chk("model_ovf", int'(m_ovf), 1);
        pct = 100; m_stalled = 0;
        run_to_done(1);
        chk("ovf_beats", beats, VW*VH - 4);
        chk("ovf_done", n_done, 1);
        chk("ovf_sticky", int'(ovf), 1);
        chk("ovf_left", exp_q.size(), 0);

        // abort mid-frame, then a clean restart
        goto_dot(1, 5);
        request(2);
        chk("ovf_cleared", int'(ovf), 0);
        wait_capture_at(2, 3);
        sb_en = 0;
        @(posedge clk); #1 cap_abort = 1'b1;
        @(posedge clk); #1 cap_abort = 1'b0;
        chk("abort_tvalid", int'(m_tvalid), 0);
        chk("abort_busy", int'(cap_busy), 0);
        exp_q.delete(); m_cap = 0; m_armed = 0;
        beats = 0; n_done = 0;
        for (int i = 0; i < FRAME_DOTS; i++) ppu_dot();
        chk("abort_no_beats", beats, 0);
        chk("abort_no_done", n_done, 0);
        sb_en = 1;
        goto_dot(0, 5);
        request(1);
        run_to_done(1);
        chk("restart_beats", beats, VW*VH);
        chk("restart_tuser", n_user, 1);
        chk("restart_done", n_done, 1);

        // async reset in the middle of a capture
        pct = 30;
        goto_dot(1, 5);
        request(1);
        wait_capture_at(1, 4);
        sb_en = 0;
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(cap_busy), 0);
        chk("arst_tvalid", int'(m_tvalid), 0);
        chk("arst_tlast", int'(m_tlast), 0);
        chk("arst_tuser", int'(m_tuser), 0);
        chk("arst_tdata", int'(m_tdata), 0);
        chk("arst_ovf", int'(ovf), 0);
        chk("arst_done", int'(cap_done), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        exp_q.delete(); m_cap = 0; m_armed = 0;
        beats = 0; n_done = 0;
        for (int i = 0; i < FRAME_DOTS + 4; i++) ppu_dot();
        chk("idle_beats", beats, 0);
        chk("idle_busy", int'(cap_busy), 0);
        chk("idle_tvalid", int'(m_tvalid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
